// File: rtl/ll_reservation_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ll_pkg
// Description : Shared helpers for the LL/SC reservation monitor: the granule
//               address compare, default widths and the channel-index width.
//               The optional reservation timeout is enabled by defining
//               LL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package ll_pkg;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_GRAN_LSB = 2;
  // Widest address the granule compare helper accepts.
  localparam int unsigned MAX_ADDR_W   = 64;

  // Channel-select width. It is never zero, so a single-channel build still
  // has a 1-bit select port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Two addresses hit the same reservation granule when they agree above
  // the ignored low bits. Callers zero-extend to MAX_ADDR_W, so the extra
  // upper bits always compare equal.
  function automatic logic gran_match(input logic [MAX_ADDR_W-1:0] a,
                                      input logic [MAX_ADDR_W-1:0] b,
                                      input int unsigned           lsb);
    return (a >> lsb) == (b >> lsb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ll_entry.sv
`default_nettype none
// ============================================================================
// Module      : ll_entry
// Description : One channel's reservation: valid flop, granule address and,
//               when LL_TIMEOUT_EN is defined, a saturating age counter.
//               The next-state logic applies these events in priority order:
//               flush, SC, LL, snoop hit, then timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_entry
  import ll_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
`ifdef LL_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1024,
`endif
  parameter int unsigned GRAN_LSB       = DEF_GRAN_LSB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              sc_clr,
  input  logic              ll_set,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              snoop_hit;

`ifdef LL_TIMEOUT_EN
  localparam int unsigned           TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]      TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0]                 timer_q, timer_d;
`endif

  // Apply the highest-priority event for this channel. The stored address
  // is kept when the reservation is cleared.
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    snoop_hit = snoop_we & valid_q &
                gran_match(MAX_ADDR_W'(addr_q), MAX_ADDR_W'(snoop_addr), GRAN_LSB);
`ifdef LL_TIMEOUT_EN
    timer_d   = (valid_q && (timer_q != TMR_MAX)) ? timer_q + 1'b1 : timer_q;
`endif
    if (flush) begin
      valid_d = 1'b0;
    end else if (sc_clr) begin
      valid_d = 1'b0;
    end else if (ll_set) begin
      valid_d = 1'b1;
      addr_d  = ll_addr;
`ifdef LL_TIMEOUT_EN
      timer_d = '0;
`endif
    end else if (snoop_hit) begin
      valid_d = 1'b0;
`ifdef LL_TIMEOUT_EN
    end else if (valid_q && (timer_q == TMR_MAX)) begin
      valid_d = 1'b0;
`endif
    end
  end

  // Reservation state registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
`ifdef LL_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
`ifdef LL_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule
`default_nettype wire

// File: rtl/ll_reservation_unit.sv
`default_nettype none
// ============================================================================
// Module      : ll_reservation_unit
// Description : Multi-channel load-linked / store-conditional reservation
//               monitor. It decodes the LL and SC requests to the channels,
//               fans the snoop out to every channel, and resolves sc_ok
//               combinationally. Define LL_TIMEOUT_EN to give each
//               reservation a lifetime of TIMEOUT_CYCLES edges.
// Revision    : 1.0 - initial release
// ============================================================================
module ll_reservation_unit
  import ll_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned GRAN_LSB       = DEF_GRAN_LSB,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CH_W          = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] flush,
  input  logic              ll_we,
  input  logic [CH_W-1:0]   ll_ch,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_req,
  input  logic [CH_W-1:0]   sc_ch,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_ok,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic [NUM_CH-1:0] llbit_o
);

  logic [ADDR_W-1:0] ch_addr [NUM_CH];

  // Reject parameter sets the design cannot build correctly.
  if ((NUM_CH < 1) || (NUM_CH > 8) || (ADDR_W > MAX_ADDR_W) || (GRAN_LSB >= ADDR_W) ||
      (TIMEOUT_CYCLES < 4) || ((TIMEOUT_CYCLES & (TIMEOUT_CYCLES - 1)) != 0))
  begin : g_param_err
    $error("ll_reservation_unit: illegal parameter combination");
  end

  // One reservation entry per channel. A channel select at or above NUM_CH
  // matches no entry, so such a request has no effect.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ll_entry #(
      .ADDR_W         (ADDR_W),
`ifdef LL_TIMEOUT_EN
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
      .GRAN_LSB       (GRAN_LSB)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[i]),
      .sc_clr     (sc_req & (sc_ch == CH_W'(i))),
      .ll_set     (ll_we & (ll_ch == CH_W'(i))),
      .ll_addr    (ll_addr),
      .snoop_we   (snoop_we),
      .snoop_addr (snoop_addr),
      .valid_o    (llbit_o[i]),
      .addr_o     (ch_addr[i])
    );
  end

  // SC succeeds only if the channel's live reservation covers sc_addr and no
  // store to that granule is observed in the same cycle.
  always_comb begin
    sc_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sc_req && (sc_ch == CH_W'(i)) && llbit_o[i] &&
          gran_match(MAX_ADDR_W'(ch_addr[i]), MAX_ADDR_W'(sc_addr), GRAN_LSB)) begin
        sc_ok = 1'b1;
      end
    end
    if (snoop_we && gran_match(MAX_ADDR_W'(snoop_addr), MAX_ADDR_W'(sc_addr), GRAN_LSB)) begin
      sc_ok = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ll_reservation_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ll_reservation_unit
// Description : Directed bench for ll_reservation_unit (NUM_CH=2, GRAN_LSB=4,
//               TIMEOUT_CYCLES=16). A behavioural reservation model is
//               compared with the DUT on every falling edge. Hand-computed
//               literals pin the key scenarios. Honours LL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ll_reservation_unit;

  localparam int NCH  = 2;
  localparam int AW   = 32;
  localparam int GL   = 4;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    flush = '0;
  logic          ll_we = 1'b0;
  logic [0:0]    ll_ch = '0;
  logic [AW-1:0] ll_addr = '0;
  logic          sc_req = 1'b0;
  logic [0:0]    sc_ch = '0;
  logic [AW-1:0] sc_addr = '0;
  logic          sc_ok;
  logic          snoop_we = 1'b0;
  logic [AW-1:0] snoop_addr = '0;
  logic [1:0]    llbit_o;

  int checks = 0;
  int errors = 0;

  ll_reservation_unit #(
    .NUM_CH(NCH), .ADDR_W(AW), .GRAN_LSB(GL), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ll_we(ll_we), .ll_ch(ll_ch), .ll_addr(ll_addr),
    .sc_req(sc_req), .sc_ch(sc_ch), .sc_addr(sc_addr), .sc_ok(sc_ok),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr), .llbit_o(llbit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_valid [NCH];
  logic [AW-1:0] m_addr  [NCH];
  int            m_ll_edge [NCH];
  int            edge_n;

  function automatic bit same_gran(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a >> GL) == (b >> GL);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_n = 0;
      for (int c = 0; c < NCH; c++) begin
        m_valid[c] = 0; m_addr[c] = '0; m_ll_edge[c] = 0;
      end
    end else begin
      edge_n++;
      for (int c = 0; c < NCH; c++) begin
        if (flush[c] || (sc_req && sc_ch == c)) m_valid[c] = 0;
        else if (ll_we && ll_ch == c) begin
          m_valid[c] = 1; m_addr[c] = ll_addr; m_ll_edge[c] = edge_n;
        end
        else if (m_valid[c] && snoop_we && same_gran(m_addr[c], snoop_addr)) m_valid[c] = 0;
`ifdef LL_TIMEOUT_EN
        // Age-based lifetime: the reservation dies TOUT edges after its LL.
        else if (m_valid[c] && (edge_n - m_ll_edge[c] >= TOUT)) m_valid[c] = 0;
`endif
      end
    end
  end

  function automatic bit exp_sc_ok();
    if (!sc_req || sc_ch >= NCH) return 0;
    if (snoop_we && same_gran(snoop_addr, sc_addr)) return 0;
    return m_valid[sc_ch] && same_gran(m_addr[sc_ch], sc_addr);
  endfunction

  always @(negedge clk) begin
    chk("model_llbit", llbit_o, {m_valid[1], m_valid[0]});
    chk("model_sc_ok", sc_ok, rst ? 1'b0 : exp_sc_ok());
  end

  // ---------------- stimulus ----------------
  // Argument order: ll_we, ll_ch, ll_addr, sc_req, sc_ch, sc_addr, snoop_we, snoop_addr, flush
  task automatic set_in(input bit lw, input int lc, input logic [AW-1:0] la,
                        input bit sr, input int sch, input logic [AW-1:0] sa,
                        input bit sw, input logic [AW-1:0] swa, input logic [1:0] fl);
    ll_we = lw; ll_ch = 1'(lc); ll_addr = la;
    sc_req = sr; sc_ch = 1'(sch); sc_addr = sa;
    snoop_we = sw; snoop_addr = swa; flush = fl;
  endtask

  task automatic cyc(input bit lw, input int lc, input logic [AW-1:0] la,
                     input bit sr, input int sch, input logic [AW-1:0] sa,
                     input bit sw, input logic [AW-1:0] swa, input logic [1:0] fl);
    @(posedge clk); #1;
    set_in(lw, lc, la, sr, sch, sa, sw, swa, fl);
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, '0, 0, 0, '0, 0, '0, 2'b00);
  endtask

  task automatic ll(input int c, input logic [AW-1:0] a);
    cyc(1, c, a, 0, 0, '0, 0, '0, 2'b00);
  endtask

  task automatic sc(input int c, input logic [AW-1:0] a);
    cyc(0, 0, '0, 1, c, a, 0, '0, 2'b00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_llbit", llbit_o, 2'b00);
    chk("reset_sc_ok", sc_ok, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // LL then SC to a different word of the same granule succeeds and clears.
    ll(0, 32'h1000);
    sc(0, 32'h1004);
    chk("t1_sc_ok", sc_ok, 1'b1);
    chk("t1_llbit_before", llbit_o, 2'b01);
    idle();
    chk("t1_llbit_after", llbit_o, 2'b00);

    // A snoop hit in the granule kills the reservation.
    ll(0, 32'h2000);
    cyc(0, 0, '0, 0, 0, '0, 1, 32'h2008, 2'b00);
    sc(0, 32'h2000);
    chk("t2_sc_ok", sc_ok, 1'b0);

    // Flushing channel 1 leaves channel 0 intact.
    ll(0, 32'h5000);
    ll(1, 32'h3000);
    cyc(0, 0, '0, 0, 0, '0, 0, '0, 2'b10);
    sc(1, 32'h3000);
    chk("t3_sc_ok_ch1", sc_ok, 1'b0);
    chk("t3_llbit", llbit_o, 2'b01);
    sc(0, 32'h5000);
    chk("t3_sc_ok_ch0", sc_ok, 1'b1);

    // One snoop clears both channels; a same-cycle snoop vetoes SC.
    ll(0, 32'h4000);
    ll(1, 32'h4000);
    cyc(0, 0, '0, 0, 0, '0, 1, 32'h4000, 2'b00);
    chk("t4_llbit_both", llbit_o, 2'b11);
    idle();
    chk("t4_llbit_cleared", llbit_o, 2'b00);
    ll(0, 32'h4000);
    cyc(0, 0, '0, 1, 0, 32'h4000, 1, 32'h400C, 2'b00);
    chk("t4_sc_snoop_veto", sc_ok, 1'b0);

    // LL and snoop to the same granule in the same cycle: LL wins.
    cyc(1, 0, 32'h6000, 0, 0, '0, 1, 32'h6000, 2'b00);
    sc(0, 32'h6000);
    chk("t5_llbit", llbit_o, 2'b01);
    chk("t5_sc_ok", sc_ok, 1'b1);

    // LL and SC on the same channel in the same cycle: SC wins, LL dropped.
    ll(1, 32'h7000);
    cyc(1, 1, 32'h7000, 1, 1, 32'h7000, 0, '0, 2'b00);
    chk("t6_sc_ok", sc_ok, 1'b1);
    idle();
    chk("t6_llbit", llbit_o, 2'b00);

    // SC to a different granule fails and still clears the reservation.
    ll(0, 32'h8000);
    sc(0, 32'h8010);
    chk("t7_sc_ok", sc_ok, 1'b0);
    idle();
    chk("t7_llbit", llbit_o, 2'b00);

    // An asynchronous reset in mid-cycle clears at once; the first edge
    // after release accepts an LL.
    ll(0, 32'h9000);
    ll(1, 32'h9000);
    #2 rst = 1'b1;
    #1 chk("t8_async_rst", llbit_o, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    set_in(1, 0, 32'h9000, 0, 0, '0, 0, '0, 2'b00);
    sc(0, 32'h9000);
    chk("t8_first_ll", sc_ok, 1'b1);

    // Lifetime: still live 15 idle edges after the LL edge; gone after 16
    // when the timeout is configured in.
    ll(0, 32'hA000);
    for (int k = 0; k < 15; k++) idle();
    sc(0, 32'hA000);
    chk("t9_sc_after_15", sc_ok, 1'b1);
    ll(0, 32'hA000);
    for (int k = 0; k < 16; k++) idle();
    sc(0, 32'hA000);
`ifdef LL_TIMEOUT_EN
    chk("t9_sc_after_16", sc_ok, 1'b0);
`else
    chk("t9_sc_after_16", sc_ok, 1'b1);
`endif
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
